spi_host_bridge: RTL and testbench

- CPU-facing front end for the SPI master engine.
- Exposes a 4-register 8-bit bus slave with a TX FIFO and an RX FIFO.
- Launches one single-byte engine transaction per TX entry and captures each received byte into the RX FIFO.
- Sits between the CPU I/O bus and the engine's enable/busy/tx_data/rx_data ports.

---
 rtl/spi_pkg.sv | 32 +++
 rtl/spi_sync_fifo.sv | 51 +++++
 rtl/spi_host_bridge.sv | 202 ++++++++++++++++++++
 tb/tb_spi_host_bridge.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: register map, STATUS/CTRL bit positions and FSM encoding shared by the SPI host bridge.
package spi_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_CLKDIV = 2'd3;

    localparam int ST_ACTIVE   = 0;
    localparam int ST_TX_EMPTY = 1;
    localparam int ST_TX_FULL  = 2;
    localparam int ST_RX_EMPTY = 3;
    localparam int ST_RX_FULL  = 4;
    localparam int ST_TX_OVF   = 5;
    localparam int ST_RX_OVF   = 6;

    localparam int CT_RUN   = 0;
    localparam int CT_CPOL  = 1;
    localparam int CT_CPHA  = 2;
    localparam int CT_SLAVE = 3;
    localparam int CT_IE_RX = 5;
    localparam int CT_IE_TX = 6;
    localparam int CT_FLUSH = 7;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/spi_sync_fifo.sv
// spi_sync_fifo: synchronous FIFO with flush; head word is visible on rdata while not empty.
// Ports: clock, reset_n (sync, active-low), flush (empties in one cycle), push/wdata,
//        pop, rdata (head), full, empty, count (occupancy, log2(DEPTH)+1 bits).
module spi_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = count == '0;
    assign full    = count == (AW+1)'(DEPTH);
    assign rdata   = mem[rptr];
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clock) begin
        if (do_push) mem[wptr] <= wdata;
    end

    always_ff @(posedge clock) begin
        if (!reset_n || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/spi_host_bridge.sv
// spi_host_bridge: CPU bus front end for the SPI master engine with TX/RX FIFOs.
// Ports: clock, reset_n (sync, active-low); bus_addr/bus_we/bus_re/bus_wdata/bus_rdata
//        (4-register slave, rdata registered); core_* engine controls driven from
//        shadow registers latched at launch; core_busy/core_rx_data from the engine;
//        irq only when SPI_IRQ_EN is defined (CTRL[6:5] enables, otherwise read as 0).
module spi_host_bridge
    import spi_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int D_WIDTH    = 8,
    parameter int SS_W       = 2,
    parameter int DIV_W      = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [1:0]         bus_addr,
    input  logic               bus_we,
    input  logic               bus_re,
    input  logic [7:0]         bus_wdata,
    output logic [7:0]         bus_rdata,
    output logic               core_enable,
    output logic               core_cpol,
    output logic               core_cpha,
    output logic               core_cont,
    output logic [DIV_W-1:0]   core_clk_div,
    output logic [SS_W-1:0]    core_addr,
    output logic [D_WIDTH-1:0] core_tx_data,
    input  logic               core_busy,
    input  logic [D_WIDTH-1:0] core_rx_data
`ifdef SPI_IRQ_EN
    ,
    output logic               irq
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t state;
    state_t state_next;

    logic         run;
    logic         cpol;
    logic         cpha;
    logic [1:0]   slave;
    logic [7:0]   clkdiv;
    logic [1:0]   ie;
    logic         tx_ovf;
    logic         rx_ovf;
    logic         rx_discard;
    logic         active;
    logic         launch;
    logic         done;
    logic         flush;
    logic         tx_push;
    logic         tx_full;
    logic         tx_empty;
    logic [D_WIDTH-1:0] tx_head;
    logic [CW-1:0] tx_count;
    logic         rx_push;
    logic         rx_pop;
    logic         rx_full;
    logic         rx_empty;
    logic [D_WIDTH-1:0] rx_head;
    logic [CW-1:0] rx_count;
    logic [7:0]   status;
    logic [7:0]   ctrl_rd;
    logic [7:0]   rd_val;
    logic         unused_counts;

    assign unused_counts = ^{tx_count, rx_count};
    assign core_cont     = 1'b0;

    assign flush   = bus_we && bus_addr == REG_CTRL && bus_wdata[CT_FLUSH];
    assign tx_push = bus_we && bus_addr == REG_DATA;
    assign rx_pop  = bus_re && bus_addr == REG_DATA && !rx_empty;
    // A byte from a transfer that was in flight during a flush is dropped.
    assign rx_push = done && !rx_discard && !flush;

    spi_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(D_WIDTH)) u_tx_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .flush   (flush),
        .push    (tx_push),
        .wdata   (D_WIDTH'(bus_wdata)),
        .pop     (launch),
        .rdata   (tx_head),
        .full    (tx_full),
        .empty   (tx_empty),
        .count   (tx_count)
    );

    spi_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(D_WIDTH)) u_rx_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .flush   (flush),
        .push    (rx_push),
        .wdata   (core_rx_data),
        .pop     (rx_pop),
        .rdata   (rx_head),
        .full    (rx_full),
        .empty   (rx_empty),
        .count   (rx_count)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (run && !tx_empty && !core_busy) state_next = LAUNCH;
            LAUNCH:    state_next = WAIT_BUSY;
            WAIT_BUSY: if (core_busy) state_next = WAIT_DONE;
            WAIT_DONE: if (!core_busy) state_next = IDLE;
        endcase
    end

    always_comb begin
        core_enable = state == LAUNCH;
        active      = state != IDLE;
        launch      = state == IDLE && state_next == LAUNCH;
        done        = state == WAIT_DONE && state_next == IDLE;
    end

`ifdef SPI_IRQ_EN
    always_ff @(posedge clock) begin
        if (!reset_n)                         ie <= 2'b00;
        else if (bus_we && bus_addr == REG_CTRL) ie <= bus_wdata[CT_IE_TX:CT_IE_RX];
    end

    always_ff @(posedge clock) begin
        if (!reset_n) irq <= 1'b0;
        else          irq <= (!rx_empty && ie[0]) || (tx_empty && !active && ie[1]);
    end
`else
    assign ie = 2'b00;
`endif

    always_comb begin
        status              = '0;
        status[ST_ACTIVE]   = active;
        status[ST_TX_EMPTY] = tx_empty;
        status[ST_TX_FULL]  = tx_full;
        status[ST_RX_EMPTY] = rx_empty;
        status[ST_RX_FULL]  = rx_full;
        status[ST_TX_OVF]   = tx_ovf;
        status[ST_RX_OVF]   = rx_ovf;
        ctrl_rd                       = '0;
        ctrl_rd[CT_RUN]               = run;
        ctrl_rd[CT_CPOL]              = cpol;
        ctrl_rd[CT_CPHA]              = cpha;
        ctrl_rd[CT_SLAVE +: 2]        = slave;
        ctrl_rd[CT_IE_TX:CT_IE_RX]    = ie;
        rd_val = bus_addr == REG_DATA   ? (rx_empty ? 8'h00 : 8'(rx_head)) :
                 bus_addr == REG_STATUS ? status :
                 bus_addr == REG_CTRL   ? ctrl_rd : clkdiv;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            run          <= 1'b0;
            cpol         <= 1'b0;
            cpha         <= 1'b0;
            slave        <= 2'b00;
            clkdiv       <= 8'h01;
            tx_ovf       <= 1'b0;
            rx_ovf       <= 1'b0;
            rx_discard   <= 1'b0;
            core_cpol    <= 1'b0;
            core_cpha    <= 1'b0;
            core_addr    <= '0;
            core_clk_div <= '0;
            core_tx_data <= '0;
            bus_rdata    <= 8'h00;
        end else begin
            if (bus_we && bus_addr == REG_CTRL) begin
                run   <= bus_wdata[CT_RUN];
                cpol  <= bus_wdata[CT_CPOL];
                cpha  <= bus_wdata[CT_CPHA];
                slave <= bus_wdata[CT_SLAVE +: 2];
            end
            if (bus_we && bus_addr == REG_CLKDIV) clkdiv <= bus_wdata;
            // Sticky flags: a new overflow in the clearing cycle wins over the W1C.
            tx_ovf <= (tx_ovf && !(bus_we && bus_addr == REG_STATUS && bus_wdata[ST_TX_OVF]))
                      || (tx_push && tx_full && !launch);
            rx_ovf <= (rx_ovf && !(bus_we && bus_addr == REG_STATUS && bus_wdata[ST_RX_OVF]))
                      || (rx_push && rx_full && !rx_pop);
            rx_discard <= flush ? (active || launch) && !done : rx_discard && !done;
            if (launch) begin
                core_tx_data <= tx_head;
                core_cpol    <= cpol;
                core_cpha    <= cpha;
                core_addr    <= SS_W'(slave);
                core_clk_div <= DIV_W'(clkdiv);
            end
            if (bus_re) bus_rdata <= rd_val;
        end
    end

endmodule

// File: tb/tb_spi_host_bridge.sv
// tb_spi_host_bridge: randomized self-checking bench with a behavioural SPI engine model.
module tb_spi_host_bridge;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] bus_addr = 2'd0;
    logic       bus_we = 1'b0;
    logic       bus_re = 1'b0;
    logic [7:0] bus_wdata = 8'h00;
    logic [7:0] bus_rdata;
    logic       core_enable;
    logic       core_cpol;
    logic       core_cpha;
    logic       core_cont;
    logic [7:0] core_clk_div;
    logic [1:0] core_addr;
    logic [7:0] core_tx_data;
    logic       core_busy = 1'b0;
    logic [7:0] core_rx_data = 8'h00;
`ifdef SPI_IRQ_EN
    logic       irq;
`endif

    spi_host_bridge dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .bus_addr     (bus_addr),
        .bus_we       (bus_we),
        .bus_re       (bus_re),
        .bus_wdata    (bus_wdata),
        .bus_rdata    (bus_rdata),
        .core_enable  (core_enable),
        .core_cpol    (core_cpol),
        .core_cpha    (core_cpha),
        .core_cont    (core_cont),
        .core_clk_div (core_clk_div),
        .core_addr    (core_addr),
        .core_tx_data (core_tx_data),
        .core_busy    (core_busy),
        .core_rx_data (core_rx_data)
`ifdef SPI_IRQ_EN
        ,
        .irq          (irq)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // Reference state: bytes accepted into TX in order, bytes the engine returned,
    // and the configuration the next launch must carry.
    logic [7:0] tx_q[$];
    logic [7:0] ret_q[$];
    logic       m_cpol = 1'b0;
    logic       m_cpha = 1'b0;
    logic [1:0] m_slave = 2'd0;
    logic [7:0] m_div = 8'h01;
    logic [7:0] rx_xor = 8'h00;
    int         launches = 0;
    int         done_cnt = 0;
    int         busy_len = 0;
    bit         rst_hit = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clock);
        bus_addr = a;
        bus_wdata = d;
        bus_we = 1'b1;
        if (a == 2'd2) begin
            m_cpol = d[1];
            m_cpha = d[2];
            m_slave = d[4:3];
        end
        if (a == 2'd3) m_div = d;
        @(negedge clock);
        bus_we = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        @(negedge clock);
        bus_addr = a;
        bus_re = 1'b1;
        @(negedge clock);
        bus_re = 1'b0;
        d = bus_rdata;
    endtask

    task automatic read_check(input string tag, input logic [1:0] a, input logic [7:0] exp);
        logic [7:0] r;
        bus_read(a, r);
        check(tag, r, exp);
    endtask

    task automatic wait_done(input int n);
        int t = 0;
        while (done_cnt < n && t < 2000) begin
            @(negedge clock);
            t++;
        end
        check("done_count", done_cnt, n);
        repeat (3) @(negedge clock);
    endtask

    task automatic wait_busy();
        int t = 0;
        while (!core_busy && t < 200) begin
            @(negedge clock);
            t++;
        end
        check("busy_seen", core_busy, 1);
    endtask

    task automatic send(input logic [7:0] b);
        tx_q.push_back(b);
        bus_write(2'd0, b);
    endtask

    // Engine model: one transaction per enable pulse, random latency and busy length,
    // returns tx ^ rx_xor as the received byte.
    initial begin : engine
        logic [7:0] t;
        logic       cp;
        logic       ch;
        logic [1:0] sl;
        logic [7:0] dv;
        int         d;
        int         n;
        forever begin
            @(negedge clock);
            if (reset_n && core_enable) begin
                launches++;
                t = core_tx_data;
                cp = core_cpol;
                ch = core_cpha;
                sl = core_addr;
                dv = core_clk_div;
                check("tx_q_nonempty", tx_q.size() > 0, 1);
                if (tx_q.size() > 0) check("tx_data", t, tx_q.pop_front());
                check("cfg_at_launch", {cp, ch, sl, dv}, {m_cpol, m_cpha, m_slave, m_div});
                d = $urandom_range(0, 2);
                n = busy_len != 0 ? busy_len : $urandom_range(1, 5);
                @(negedge clock);
                check("en_pulse", core_enable, 0);
                repeat (d) @(negedge clock);
                core_busy = 1'b1;
                repeat (n) begin
                    @(negedge clock);
                    if (!rst_hit)
                        check("cfg_stable", {core_cpol, core_cpha, core_addr, core_clk_div}, {cp, ch, sl, dv});
                end
                core_rx_data = t ^ rx_xor;
                core_busy = 1'b0;
                ret_q.push_back(t ^ rx_xor);
                done_cnt++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] r;
        logic [7:0] b;
        logic [7:0] c1;
        logic [7:0] c2;
        logic [7:0] d1;
        logic [7:0] d2;
        int         exp_done = 0;
        int         n;

        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("rst_outs", {core_enable, core_cpol, core_cpha, core_cont, core_clk_div, core_addr, core_tx_data, bus_rdata}, 0);
        read_check("rst_status", 2'd1, 8'h0A);
        read_check("rst_clkdiv", 2'd3, 8'h01);
        read_check("rst_ctrl", 2'd2, 8'h00);
        bus_write(2'd2, 8'h60);
`ifdef SPI_IRQ_EN
        read_check("ctrl_ie_bits", 2'd2, 8'h60);
`else
        read_check("ctrl_ie_bits", 2'd2, 8'h00);
`endif
        bus_write(2'd2, 8'h00);

        // Single loopback transfer.
        bus_write(2'd2, 8'h01);
        send(8'hA5);
        exp_done++;
        wait_done(exp_done);
        check("one_launch", launches, 1);
        read_check("loop_data", 2'd0, ret_q.pop_front());
        read_check("loop_status", 2'd1, 8'h0A);
        repeat (3) @(negedge clock);
        check("rdata_hold", bus_rdata, 8'h0A);
        read_check("empty_read", 2'd0, 8'h00);
        read_check("empty_status", 2'd1, 8'h0A);

        // TX overflow with run off, W1C, then drain in order.
        bus_write(2'd2, 8'h00);
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            if (i < 4) tx_q.push_back(b);
            bus_write(2'd0, b);
        end
        read_check("tx_ovf_status", 2'd1, 8'h2C);
        bus_write(2'd1, 8'h20);
        read_check("tx_ovf_clr", 2'd1, 8'h0C);
        rx_xor = 8'($urandom);
        bus_write(2'd2, 8'h01);
        exp_done += 4;
        wait_done(exp_done);
        for (int i = 0; i < 4; i++) read_check("drain_data", 2'd0, ret_q.pop_front());
        read_check("drain_status", 2'd1, 8'h0A);

        // RX overflow on the fifth unread transfer.
        rx_xor = 8'($urandom);
        for (int i = 0; i < 5; i++) begin
            send(8'($urandom));
            exp_done++;
            wait_done(exp_done);
            if (i == 3) read_check("rx_full_status", 2'd1, 8'h12);
        end
        read_check("rx_ovf_status", 2'd1, 8'h52);
        for (int i = 0; i < 4; i++) read_check("rx_order", 2'd0, ret_q.pop_front());
        ret_q.delete();
        read_check("rx_ovf_after", 2'd1, 8'h4A);
        bus_write(2'd1, 8'h40);
        read_check("rx_ovf_clr", 2'd1, 8'h0A);

        // Config change mid-transfer applies only to the next launch.
        c1 = {3'b000, 2'($urandom), 2'($urandom), 1'b1};
        c2 = c1 ^ 8'h1E;
        d1 = 8'($urandom);
        d2 = ~d1;
        bus_write(2'd3, d1);
        bus_write(2'd2, c1);
        busy_len = 14;
        send(8'($urandom));
        exp_done++;
        wait_busy();
        bus_write(2'd2, c2);
        bus_write(2'd3, d2);
        check("shadow_mid", {core_cpol, core_cpha, core_addr, core_clk_div}, {c1[1], c1[2], c1[4:3], d1});
        read_check("ctrl_new", 2'd2, c2);
        wait_done(exp_done);
        check("shadow_hold", {core_cpol, core_cpha, core_addr, core_clk_div}, {c1[1], c1[2], c1[4:3], d1});
        busy_len = 0;
        send(8'($urandom));
        exp_done++;
        wait_done(exp_done);
        check("shadow_next", {core_cpol, core_cpha, core_addr, core_clk_div}, {c2[1], c2[2], c2[4:3], d2});
        for (int i = 0; i < 2; i++) read_check("cfg_data", 2'd0, ret_q.pop_front());

        // Randomized bursts.
        for (int k = 0; k < 12; k++) begin
            n = $urandom_range(1, 4);
            rx_xor = 8'($urandom);
            bus_write(2'd3, 8'($urandom));
            bus_write(2'd2, {3'b000, 4'($urandom), 1'b1});
            for (int i = 0; i < n; i++) send(8'($urandom));
            exp_done += n;
            wait_done(exp_done);
            for (int i = 0; i < n; i++) read_check("burst_data", 2'd0, ret_q.pop_front());
            read_check("burst_status", 2'd1, 8'h0A);
        end

        // Clearing run mid-transfer: current byte completes, no further launch.
        bus_write(2'd2, 8'h01);
        for (int i = 0; i < 3; i++) send(8'($urandom));
        wait_busy();
        bus_write(2'd2, 8'h00);
        exp_done++;
        wait_done(exp_done);
        repeat (10) @(negedge clock);
        check("run_clear_launches", launches, exp_done);
        read_check("run_clear_status", 2'd1, 8'h00);
        bus_write(2'd2, 8'h80);
        tx_q.delete();
        ret_q.delete();
        read_check("flush_status", 2'd1, 8'h0A);
        read_check("flush_ctrl", 2'd2, 8'h00);

        // Flush during a transfer discards its RX byte.
        bus_write(2'd2, 8'h01);
        send(8'($urandom));
        exp_done++;
        wait_busy();
        bus_write(2'd2, 8'h81);
        wait_done(exp_done);
        ret_q.delete();
        read_check("flush_mid_status", 2'd1, 8'h0A);
        read_check("flush_mid_data", 2'd0, 8'h00);

`ifdef SPI_IRQ_EN
        bus_write(2'd2, 8'h21);
        send(8'($urandom));
        exp_done++;
        wait_done(exp_done);
        check("irq_set", irq, 1);
        read_check("irq_data", 2'd0, ret_q.pop_front());
        @(negedge clock);
        check("irq_clr", irq, 0);
`endif

        // Reset in the middle of a transfer.
        bus_write(2'd3, 8'h7E);
        bus_write(2'd2, 8'h1F);
        send(8'($urandom));
        wait_busy();
        rst_hit = 1'b1;
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        tx_q.delete();
        check("rst_mid_outs", {core_enable, core_cpol, core_cpha, core_clk_div, core_addr, core_tx_data, bus_rdata}, 0);
        read_check("rst_mid_status", 2'd1, 8'h0A);
        read_check("rst_mid_ctrl", 2'd2, 8'h00);
        read_check("rst_mid_clkdiv", 2'd3, 8'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
